// File: rtl/ringosc_freq_meter_if.sv
// Measurement bus of the ring-oscillator frequency meter: signal under test,
// run control and per-window results.
interface ringosc_freq_meter_if #(
  parameter int CNT_W = 32
);
  logic             sig_in;
  logic             enable;
  logic             clear_max;
  logic [CNT_W-1:0] freq_count;
  logic             freq_valid;
  logic [CNT_W-1:0] count_max;
  logic             overflow;
  logic             busy;

  modport master (
    output sig_in, enable, clear_max,
    input  freq_count, freq_valid, count_max, overflow, busy
  );

  modport slave (
    input  sig_in, enable, clear_max,
    output freq_count, freq_valid, count_max, overflow, busy
  );
endinterface

// File: rtl/ringosc_freq_meter.sv
// Counts synchronised rising edges of sig_in over back-to-back GATE_CYCLES windows,
// publishing each window's count with a valid pulse and tracking the peak count.
module ringosc_freq_meter #(
  parameter logic [31:0] GATE_CYCLES = 32'd50000000,
  parameter int          CNT_W       = 32,
  parameter int          SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  ringosc_freq_meter_if.slave mif
);

  typedef enum logic {IDLE, GATE} state_t;

  localparam logic [31:0]      GATE_LAST = GATE_CYCLES - 32'd1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_d;
  logic                   edge_pulse;
  logic [31:0]            gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   sat;
  logic [CNT_W-1:0]       fc_q;
  logic [CNT_W-1:0]       cm_q;
  logic                   vld_q;
  logic                   ov_q;

  logic                   last_cycle;
  logic                   at_max;
  logic                   win_start;
  logic [CNT_W-1:0]       cnt_next;
  logic                   sat_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      sync_d     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], mif.sig_in};
      sync_d     <= sync[SYNC_STAGES-1];
      edge_pulse <= sync[SYNC_STAGES-1] & ~sync_d;
    end
  end

  // The closing count folds in a pulse landing on the last gate cycle, so a
  // restart in the same cycle neither drops nor double-counts it.
  assign last_cycle = (state == GATE) && (gate_cnt == GATE_LAST);
  assign at_max     = (edge_cnt == CNT_MAX);
  assign cnt_next   = (edge_pulse && !at_max) ? edge_cnt + CNT_ONE : edge_cnt;
  assign sat_next   = sat | (edge_pulse & at_max);
  assign win_start  = mif.enable && ((state == IDLE) || last_cycle);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mif.enable)  state_nxt = GATE;
      GATE:    if (!mif.enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else if (win_start) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else if (state == GATE) begin
      gate_cnt <= gate_cnt + 32'd1;
      edge_cnt <= cnt_next;
      sat      <= sat_next;
    end
  end

  // A clear landing on the valid cycle keeps that window's count, matching a
  // clear that coincides with the update edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_q  <= '0;
      cm_q  <= '0;
      vld_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      vld_q <= last_cycle;
      if (last_cycle) begin
        fc_q <= cnt_next;
        ov_q <= sat_next;
        if (mif.clear_max || (cnt_next > cm_q)) cm_q <= cnt_next;
      end else if (mif.clear_max) begin
        cm_q <= vld_q ? fc_q : '0;
      end
    end
  end

  assign mif.freq_count = fc_q;
  assign mif.freq_valid = vld_q;
  assign mif.count_max  = cm_q;
  assign mif.overflow   = ov_q;
  assign mif.busy       = (state == GATE);

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Bench for ringosc_freq_meter: a 32-bit and a 4-bit instance, window-level model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ringosc_freq_meter;
  localparam int N   = 100;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic gen_sig[2];
  logic man_sig[2];
  logic en[2];
  logic clr[2];
  int   req[2];
  int   cur[2];
  int   ph[2];

  ringosc_freq_meter_if #(.CNT_W(32)) if0 ();
  ringosc_freq_meter_if #(.CNT_W(4))  if1 ();

  assign if0.sig_in    = gen_sig[0] | man_sig[0];
  assign if0.enable    = en[0];
  assign if0.clear_max = clr[0];
  assign if1.sig_in    = gen_sig[1] | man_sig[1];
  assign if1.enable    = en[1];
  assign if1.clear_max = clr[1];

  ringosc_freq_meter #(.GATE_CYCLES(32'd100), .CNT_W(32), .SYNC_STAGES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .mif(if0));
  ringosc_freq_meter #(.GATE_CYCLES(32'd100), .CNT_W(4), .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .mif(if1));

  logic [31:0] d_fc[2];
  logic [31:0] d_cm[2];
  logic        d_vld[2];
  logic        d_ov[2];
  logic        d_busy[2];
  assign d_fc[0]   = if0.freq_count;
  assign d_fc[1]   = 32'(if1.freq_count);
  assign d_cm[0]   = if0.count_max;
  assign d_cm[1]   = 32'(if1.count_max);
  assign d_vld[0]  = if0.freq_valid;
  assign d_vld[1]  = if1.freq_valid;
  assign d_ov[0]   = if0.overflow;
  assign d_ov[1]   = if1.overflow;
  assign d_busy[0] = if0.busy;
  assign d_busy[1] = if1.busy;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d at t=%0t", nm, act, lo, hi, $time);
    end
  endtask

  task automatic wait_valid(input int i);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!d_vld[i] && k < 400);
    chk("valid_arrives", d_vld[i], 1);
  endtask

  // Square-wave source; period changes take effect at the next rising edge.
  initial begin
    for (int i = 0; i < 2; i++) begin
      gen_sig[i] = 1'b0;
      cur[i]     = 0;
      ph[i]      = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (cur[i] == 0) begin
          if (req[i] != 0) begin
            cur[i] = req[i];
            ph[i] = 0;
            gen_sig[i] = 1'b1;
          end
        end else begin
          ph[i]++;
          if (ph[i] == cur[i]) begin
            ph[i] = 0;
            cur[i] = req[i];
            gen_sig[i] = (cur[i] != 0);
          end else begin
            gen_sig[i] = (ph[i] < cur[i] / 2);
          end
        end
      end
    end
  end

  // Window model: a rise first seen in cycle c yields a pulse in cycle c+LAT;
  // a window's count is the number of pulses inside its N cycles, clipped.
  int     cyc = 0;
  int     pq[2][$];
  logic   m_prev[2] = '{1'b0, 1'b0};
  logic   m_act[2]  = '{1'b0, 1'b0};
  int     m_ws[2]   = '{0, 0};
  longint m_mx[2]   = '{64'hFFFF_FFFF, 64'd15};
  longint e_fc[2]   = '{0, 0};
  longint e_cm[2]   = '{0, 0};
  logic   e_ov[2]   = '{1'b0, 1'b0};
  int     e_vcyc[2] = '{-1, -1};

  always @(negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      pq[i].delete();
      m_prev[i] = 1'b0;
      m_act[i]  = 1'b0;
      e_fc[i]   = 0;
      e_cm[i]   = 0;
      e_ov[i]   = 1'b0;
      e_vcyc[i] = -1;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        automatic logic s = gen_sig[i] | man_sig[i];
        automatic longint n = 0;
        if (s && !m_prev[i]) pq[i].push_back(cyc + LAT);
        m_prev[i] = s;
        if (m_act[i] && (cyc - m_ws[i] == N - 1)) begin
          while (pq[i].size() > 0 && pq[i][0] <= cyc) begin
            if (pq[i][0] >= m_ws[i]) n++;
            void'(pq[i].pop_front());
          end
          e_ov[i]   = (n > m_mx[i]);
          e_fc[i]   = e_ov[i] ? m_mx[i] : n;
          e_vcyc[i] = cyc + 1;
          if (clr[i] || e_fc[i] > e_cm[i]) e_cm[i] = e_fc[i];
          if (en[i]) m_ws[i] = cyc + 1;
          else       m_act[i] = 1'b0;
        end else begin
          if (clr[i]) e_cm[i] = (e_vcyc[i] == cyc) ? e_fc[i] : 0;
          if (m_act[i] && !en[i]) m_act[i] = 1'b0;
          else if (!m_act[i] && en[i]) begin
            m_act[i] = 1'b1;
            m_ws[i]  = cyc + 1;
          end
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk(i == 0 ? "u0_freq_count" : "u1_freq_count", d_fc[i], e_fc[i]);
      chk(i == 0 ? "u0_count_max" : "u1_count_max", d_cm[i], e_cm[i]);
      chk(i == 0 ? "u0_overflow" : "u1_overflow", d_ov[i], e_ov[i]);
      chk(i == 0 ? "u0_freq_valid" : "u1_freq_valid", d_vld[i], cyc == e_vcyc[i]);
      chk(i == 0 ? "u0_busy" : "u1_busy", d_busy[i], m_act[i]);
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int k;
    int nv;
    for (int i = 0; i < 2; i++) begin
      man_sig[i] = 1'b0;
      en[i]      = 1'b0;
      clr[i]     = 1'b0;
      req[i]     = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_freq_count", d_fc[i], 0);
      chk("rst_count_max", d_cm[i], 0);
      chk("rst_valid", d_vld[i], 0);
      chk("rst_overflow", d_ov[i], 0);
      chk("rst_busy", d_busy[i], 0);
    end
    #2 rst_n = 1'b1;

    // Saturation on the 4-bit instance: 25 edges clip to 15.
    @(negedge clk);
    req[1] = 4;
    en[1]  = 1'b1;
    wait_valid(1);
    chk("sat_count", d_fc[1], 15);
    chk("sat_overflow", d_ov[1], 1);
    req[1] = 20;
    wait_valid(1);
    wait_valid(1);
    chk("slow_count", d_fc[1], 5);
    chk("slow_overflow", d_ov[1], 0);
    en[1]  = 1'b0;
    req[1] = 0;

    // Nominal and peak tracking.
    @(negedge clk);
    req[0] = 10;
    en[0]  = 1'b1;
    wait_valid(0);
    chk_rng("nom_first", d_fc[0], 9, 11);
    wait_valid(0);
    chk("nom_count", d_fc[0], 10);
    chk("nom_overflow", d_ov[0], 0);
    chk("nom_busy", d_busy[0], 1);
    chk("peak_10", d_cm[0], 10);
    req[0] = 5;
    wait_valid(0);
    wait_valid(0);
    chk("fast_count", d_fc[0], 20);
    chk("peak_20", d_cm[0], 20);
    req[0] = 10;
    wait_valid(0);
    wait_valid(0);
    chk("back_count", d_fc[0], 10);
    chk("peak_hold", d_cm[0], 20);

    // Clear asserted across the update edge and the valid cycle.
    repeat (99) @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    chk("coinc_valid", d_vld[0], 1);
    @(negedge clk);
    clr[0] = 1'b0;
    chk("coinc_clear", d_cm[0], 10);

    repeat (5) @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    @(negedge clk);
    chk("clear_zero", d_cm[0], 0);
    wait_valid(0);
    chk("clear_refill", d_cm[0], 10);

    // Abort at cycle 50 of a window.
    repeat (50) @(negedge clk);
    chk("abort_busy_before", d_busy[0], 1);
    en[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy_after", d_busy[0], 0);
    nv = 0;
    repeat (150) begin
      @(negedge clk);
      if (d_vld[0]) nv++;
    end
    chk("abort_no_valid", nv, 0);
    chk("abort_keeps_count", d_fc[0], 10);

    // Asynchronous reset at cycle 60 of a window.
    en[0] = 1'b1;
    @(negedge clk);
    repeat (60) @(negedge clk);
    chk("pre_reset_busy", d_busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_count", d_fc[0], 0);
    chk("areset_max", d_cm[0], 0);
    chk("areset_busy", d_busy[0], 0);
    chk("areset_valid", d_vld[0], 0);
    chk("areset_overflow", d_ov[0], 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!d_vld[0] && k < 400);
    chk("reset_valid_latency", k, 101);
    chk_rng("reset_full_count", d_fc[0], 9, 11);

    // Window boundary: one pulse on the last gate cycle, one mid next window.
    req[0] = 0;
    wait_valid(0);
    wait_valid(0);
    chk("quiet_count", d_fc[0], 0);
    repeat (N - LAT - 1) @(negedge clk);
    man_sig[0] = 1'b1;
    wait_valid(0);
    man_sig[0] = 1'b0;
    chk("boundary_closing", d_fc[0], 1);
    repeat (40) @(negedge clk);
    man_sig[0] = 1'b1;
    repeat (5) @(negedge clk);
    man_sig[0] = 1'b0;
    wait_valid(0);
    chk("boundary_next", d_fc[0], 1);
    en[0] = 1'b0;

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ringosc_freq_meter.md
Name: ringosc_freq_meter

Overview:
- Measures the frequency of the free-running ring-oscillator test signal (raw oscillator or its divided LED-rate output) against the board system clock.
- Sits directly downstream of the ring-oscillator/divider stage in the max_perf test design.
- Synchronises the asynchronous input and counts its rising edges over a fixed gate window.
- Publishes each window's count with a valid strobe, and tracks the peak count for max-performance characterisation.

Parameters:
- GATE_CYCLES, 50000000, gate window length in clk cycles (1 s at 50 MHz); legal range 2..2^32-1.
- CNT_W, 32, width of edge counter and result registers.
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser; minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sig_in  input  1  asynchronous signal under measurement; high and low phases each >1 clk period.
- enable  input  1  1 = run continuous back-to-back windows; 0 = idle.
- clear_max  input  1  synchronous clear of count_max.
- freq_count  output  CNT_W  edge count of the last completed window.
- freq_valid  output  1  one-cycle pulse when freq_count updates.
- count_max  output  CNT_W  largest freq_count since reset or clear_max.
- overflow  output  1  sticky flag for the last completed window: edge counter saturated.
- busy  output  1  high while a window is in progress.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0; synchroniser, edge counter, gate counter and state cleared. Reset mid-window discards the partial count.
- Synchroniser and edge detect:
  - sig_in passes through SYNC_STAGES flops, then a 1-flop edge detector.
  - A rising edge on sig_in produces edge_pulse SYNC_STAGES+1 cycles later (3 with default).
  - Inputs faster than clk/2 alias; no requirement beyond no lockup.
- States:
  - IDLE -> GATE when enable is sampled 1. Edge counter and gate counter load 0 in that cycle.
  - GATE counts exactly GATE_CYCLES cycles, starting the cycle after entry.
  - GATE, last cycle (gate counter = GATE_CYCLES-1):
    - freq_count <= edge count including any edge_pulse in that cycle.
    - overflow <= saturation flag.
    - freq_valid = 1 in the following cycle.
    - If enable = 1: the next window starts immediately with counters reset. There are no dead cycles and no lost or double-counted edges.
    - If enable = 0: go to IDLE.
  - GATE with enable sampled 0 before the last cycle: abort to IDLE next cycle. No freq_valid; freq_count, overflow and count_max unchanged.
- busy = 1 whenever the state is GATE; it falls in the cycle after the abort or final window.
- Edge counter saturates at 2^CNT_W-1; any further edge_pulse sets the window's saturation flag. The flag clears at window start.
- count_max:
  - Updates in the same cycle as freq_valid when the new freq_count > count_max (unsigned compare).
  - clear_max sets count_max to 0.
  - If clear_max and an update coincide, the cleared-then-updated value wins: count_max = new freq_count.
- freq_count holds its value between valid strobes.

Test Plan:
- Nominal: GATE_CYCLES=100, sig_in period 10 clk, enable held 1 -> freq_valid every 100 cycles; freq_count=10 (tolerance ±1 on the first window only); overflow=0; busy stays 1.
- Saturation: CNT_W=4, GATE_CYCLES=100, sig_in period 4 clk -> freq_count=15, overflow=1. Then period 20 clk -> next window freq_count=5, overflow=0.
- Abort: enable drops at cycle 50 of a window -> busy=0 one cycle later; no freq_valid; freq_count retains the previous value (10).
- Async reset mid-window: rst_n low for 3 cycles at cycle 60 -> all outputs 0 immediately. After release with enable=1, the first valid arrives 101 cycles after IDLE exit with a full count.
- Peak tracking: period 10 for 2 windows, period 5 for 1, period 10 again -> count_max = 10, 20, 20. clear_max pulse -> 0, then 10 on the next valid. clear_max coincident with valid -> count_max = that valid's count.
- Window boundary: a sig_in edge timed so edge_pulse lands on the last gate cycle -> counted in the closing window only; the next window's count excludes it (sum over two windows equals total edges).
